// File: rtl/perf_fpga_engine_scheduler_pkg.sv
// Shared types and request encodings for the perf engine schedulers.
package perf_sched_pkg;

   localparam logic [1:0] REQ_READ  = 2'b01;
   localparam logic [1:0] REQ_WRITE = 2'b10;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} top_state_t;

   typedef enum logic [1:0] {FREE, ISSUED, RUNNING} slot_state_t;

   function automatic logic is_legal_req(input logic [1:0] req_type);
      return (req_type == REQ_READ) || (req_type == REQ_WRITE);
   endfunction

endpackage

// File: rtl/perf_fpga_engine_scheduler_if.sv
// Host command/status and engine-bank signals of the run-level scheduler.
interface perf_fpga_engine_scheduler_if #(
   parameter int N_ENGINES = 4
);
   logic                      start;
   logic [1:0]                cmd_type;
   logic [31:0]               cmd_n_reqs;
   logic [63:0]               cmd_n_beats;
   logic [2*N_ENGINES-1:0]    eng_req_type;
   logic [64*N_ENGINES-1:0]   eng_n_beats;
   logic [N_ENGINES-1:0]      eng_busy;
   logic [N_ENGINES-1:0]      eng_done;
   logic                      run_busy;
   logic                      run_done;
   logic                      run_err;
   logic [63:0]               cycles;
   logic [31:0]               n_issued;
   logic [31:0]               n_completed;

   modport master (
      input  start, cmd_type, cmd_n_reqs, cmd_n_beats, eng_busy, eng_done,
      output eng_req_type, eng_n_beats, run_busy, run_done, run_err,
             cycles, n_issued, n_completed
   );

   modport slave (
      output start, cmd_type, cmd_n_reqs, cmd_n_beats, eng_busy, eng_done,
      input  eng_req_type, eng_n_beats, run_busy, run_done, run_err,
             cycles, n_issued, n_completed
   );

endinterface

// File: rtl/perf_fpga_engine_scheduler_rr_arbiter.sv
// N-input round-robin arbiter: one-hot grant, search starts just after the last winner.
module perf_rr_arbiter #(
   parameter int N = 4
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic [N-1:0]                      req,
   input  logic                              advance,
   output logic [N-1:0]                      grant,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
   output logic                              grant_valid
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!grant_valid && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            grant_valid = 1'b1;
         end
      end
   end

   // The pointer only moves when the grant is actually consumed.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ptr <= '0;
      end else if (advance && grant_valid) begin
         ptr <= grant_idx;
      end
   end

endmodule

// File: rtl/perf_fpga_engine_scheduler.sv
// Run-level scheduler: issues a benchmark run's requests round-robin to a bank of engines
// and tracks each engine through its busy signal.
module perf_fpga_engine_scheduler
   import perf_sched_pkg::*;
#(
   parameter int N_ENGINES     = 4,
   parameter int ISSUE_TIMEOUT = 256
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   perf_fpga_engine_scheduler_if.master   bus
);

   localparam int IW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
   localparam int TW = $clog2(ISSUE_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ISSUE_TIMEOUT - 1);

   top_state_t    state;
   slot_state_t   slot_q  [N_ENGINES];
   logic [TW-1:0] tmo_cnt [N_ENGINES];

   logic [1:0]  req_type_q;
   logic [31:0] n_reqs_q;
   logic [63:0] n_beats_q;
   logic        run_busy_q, run_done_q, run_err_q;
   logic [63:0] cycles_q;
   logic [31:0] n_issued_q, n_completed_q;

   logic [N_ENGINES-1:0] slot_req, grant, slot_done, slot_tmo;
   logic [IW-1:0]        grant_idx_unused;
   logic                 grant_valid, issue_ok, grant_fire;
   logic [31:0]          n_freed;
   logic                 eng_done_unused;

   // eng_done toggles while engines idle, so accounting relies on busy alone.
   assign eng_done_unused = ^bus.eng_done;

   always_comb begin
      slot_req  = '0;
      slot_done = '0;
      slot_tmo  = '0;
      n_freed   = '0;
      for (int i = 0; i < N_ENGINES; i++) begin
         slot_req[i]  = (slot_q[i] == FREE) && !bus.eng_busy[i];
         slot_tmo[i]  = (slot_q[i] == ISSUED) && !bus.eng_busy[i] && (tmo_cnt[i] == TMO_LAST);
         slot_done[i] = ((slot_q[i] == RUNNING) && !bus.eng_busy[i]) || slot_tmo[i];
         n_freed      = n_freed + 32'(slot_done[i]);
      end
   end

   assign issue_ok   = (state == RUN) && (n_issued_q < n_reqs_q);
   assign grant_fire = issue_ok && grant_valid;

   perf_rr_arbiter #(.N(N_ENGINES)) u_arb (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .req         (slot_req),
      .advance     (issue_ok),
      .grant       (grant),
      .grant_idx   (grant_idx_unused),
      .grant_valid (grant_valid)
   );

   always_comb begin
      bus.eng_req_type = '0;
      bus.eng_n_beats  = '0;
      for (int i = 0; i < N_ENGINES; i++) begin
         if (grant_fire && grant[i]) begin
            bus.eng_req_type[2*i +: 2]  = req_type_q;
            bus.eng_n_beats[64*i +: 64] = n_beats_q;
         end
      end
   end

   // A slot that frees this cycle is still RUNNING/ISSUED to the arbiter, so it is grantable next cycle.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < N_ENGINES; i++) begin
            slot_q[i]  <= FREE;
            tmo_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_ENGINES; i++) begin
            case (slot_q[i])
               FREE: begin
                  if (grant_fire && grant[i]) begin
                     slot_q[i]  <= ISSUED;
                     tmo_cnt[i] <= '0;
                  end
               end
               ISSUED: begin
                  if (bus.eng_busy[i]) begin
                     slot_q[i] <= RUNNING;
                  end else if (slot_tmo[i]) begin
                     slot_q[i] <= FREE;
                  end else begin
                     tmo_cnt[i] <= tmo_cnt[i] + 1'b1;
                  end
               end
               RUNNING: begin
                  if (!bus.eng_busy[i]) begin
                     slot_q[i] <= FREE;
                  end
               end
               default: slot_q[i] <= FREE;
            endcase
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state         <= IDLE;
         req_type_q    <= '0;
         n_reqs_q      <= '0;
         n_beats_q     <= '0;
         run_busy_q    <= 1'b0;
         run_done_q    <= 1'b0;
         run_err_q     <= 1'b0;
         cycles_q      <= '0;
         n_issued_q    <= '0;
         n_completed_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               run_done_q <= 1'b0;
               if (bus.start && is_legal_req(bus.cmd_type)) begin
                  req_type_q    <= bus.cmd_type;
                  n_reqs_q      <= bus.cmd_n_reqs;
                  n_beats_q     <= bus.cmd_n_beats;
                  cycles_q      <= '0;
                  n_issued_q    <= '0;
                  n_completed_q <= '0;
                  run_err_q     <= 1'b0;
                  run_busy_q    <= 1'b1;
                  state         <= RUN;
               end
            end
            RUN: begin
               if (cycles_q != '1) begin
                  cycles_q <= cycles_q + 64'd1;
               end
               if (grant_fire) begin
                  n_issued_q <= n_issued_q + 32'd1;
               end
               n_completed_q <= n_completed_q + n_freed;
               if (|slot_tmo) begin
                  run_err_q <= 1'b1;
               end
               if (n_completed_q == n_reqs_q) begin
                  run_busy_q <= 1'b0;
                  run_done_q <= 1'b1;
                  state      <= FINISH;
               end
            end
            FINISH: begin
               run_done_q <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.run_busy    = run_busy_q;
   assign bus.run_done    = run_done_q;
   assign bus.run_err     = run_err_q;
   assign bus.cycles      = cycles_q;
   assign bus.n_issued    = n_issued_q;
   assign bus.n_completed = n_completed_q;

endmodule

// File: tb/tb_perf_fpga_engine_scheduler.sv
// Directed bench for perf_fpga_engine_scheduler with four behavioural engines (1 beat/cycle).
module tb_perf_fpga_engine_scheduler;
   import perf_sched_pkg::*;

   localparam int N = 4;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;

   always #5 aclk = ~aclk;

   perf_fpga_engine_scheduler_if #(.N_ENGINES(N)) bus ();

   perf_fpga_engine_scheduler #(.N_ENGINES(N), .ISSUE_TIMEOUT(256)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   logic [63:0]  remain [N];
   logic [N-1:0] dead;
   logic [N-1:0] busyVec;

   int          passCount  = 0;
   int          checkCount = 0;
   int          grantCount, doneCount, badField, multiIssue, monHits;
   logic [63:0] orderCode;
   logic [1:0]  expType;
   logic [63:0] expBeats;
   int          waited;

   // Engine model: busy for n_beats cycles after the issue cycle, one cycle for zero beats.
   always @(posedge aclk) begin
      for (int i = 0; i < N; i++) begin
         if (!aresetn) begin
            remain[i] <= '0;
         end else if (bus.eng_req_type[2*i +: 2] != 2'b00 && !dead[i]) begin
            remain[i] <= (bus.eng_n_beats[64*i +: 64] == 64'd0) ? 64'd1 : bus.eng_n_beats[64*i +: 64];
         end else if (remain[i] != 64'd0) begin
            remain[i] <= remain[i] - 64'd1;
         end
      end
   end

   always_comb begin
      busyVec = '0;
      for (int i = 0; i < N; i++) begin
         busyVec[i] = (remain[i] != 64'd0);
      end
   end

   assign bus.eng_busy = busyVec;
   assign bus.eng_done = ~busyVec;

   // Records issue order (one hex digit per grant) and issue-field sanity.
   always @(negedge aclk) begin
      monHits = 0;
      for (int i = 0; i < N; i++) begin
         if (bus.eng_req_type[2*i +: 2] != 2'b00) begin
            monHits++;
            grantCount++;
            orderCode = (orderCode << 4) | 64'(i);
            if (bus.eng_req_type[2*i +: 2] != expType || bus.eng_n_beats[64*i +: 64] != expBeats) begin
               badField++;
            end
         end else if (bus.eng_n_beats[64*i +: 64] != 64'd0) begin
            badField++;
         end
      end
      if (monHits > 1) multiIssue++;
      if (bus.run_done) doneCount++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
      end
   endtask

   task automatic resetMonitors(input logic [1:0] t, input logic [63:0] b);
      @(negedge aclk);
      orderCode  = '0;
      grantCount = 0;
      doneCount  = 0;
      badField   = 0;
      multiIssue = 0;
      expType    = t;
      expBeats   = b;
   endtask

   task automatic applyStimulus(input logic [1:0] t, input logic [31:0] n, input logic [63:0] b);
      @(negedge aclk);
      bus.start       = 1'b1;
      bus.cmd_type    = t;
      bus.cmd_n_reqs  = n;
      bus.cmd_n_beats = b;
      @(negedge aclk);
      bus.start = 1'b0;
   endtask

   task automatic waitRunDone(input string tag, input int budget, output int k);
      k = 0;
      while (!bus.run_done && k < budget) begin
         @(negedge aclk);
         k++;
      end
      checkOutput(tag, 64'(bus.run_done), 64'd1);
   endtask

   task automatic checkIdle(input string tag);
      @(negedge aclk);
      checkOutput({tag, "_busy_low"}, 64'(bus.run_busy), 64'd0);
      checkOutput({tag, "_done_pulses"}, 64'(doneCount), 64'd1);
      checkOutput({tag, "_fields"}, 64'(badField + multiIssue), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      bus.start       = 1'b0;
      bus.cmd_type    = 2'b00;
      bus.cmd_n_reqs  = '0;
      bus.cmd_n_beats = '0;
      dead            = '0;
      orderCode = '0; grantCount = 0; doneCount = 0; badField = 0; multiIssue = 0;
      expType = 2'b00; expBeats = '0;
      repeat (3) @(negedge aclk);
      checkOutput("rst_busy", 64'(bus.run_busy), 64'd0);
      checkOutput("rst_cycles", bus.cycles, 64'd0);
      checkOutput("rst_issued", 64'(bus.n_issued), 64'd0);
      checkOutput("rst_eng_req", 64'(bus.eng_req_type), 64'd0);
      aresetn = 1'b1;

      // Write, 8 reqs x 16 beats
      resetMonitors(REQ_WRITE, 64'd16);
      applyStimulus(REQ_WRITE, 32'd8, 64'd16);
      checkOutput("t1_busy", 64'(bus.run_busy), 64'd1);
      waitRunDone("t1_done", 200, waited);
      checkOutput("t1_issued", 64'(bus.n_issued), 64'd8);
      checkOutput("t1_completed", 64'(bus.n_completed), 64'd8);
      checkOutput("t1_cycles", bus.cycles, 64'd40);
      checkOutput("t1_order", orderCode, 64'h12301230);
      checkIdle("t1");

      // Read, 1 req x 0 beats
      resetMonitors(REQ_READ, 64'd0);
      applyStimulus(REQ_READ, 32'd1, 64'd0);
      waitRunDone("t2_done", 50, waited);
      checkOutput("t2_order", orderCode, 64'h1);
      checkOutput("t2_grants", 64'(grantCount), 64'd1);
      checkOutput("t2_completed", 64'(bus.n_completed), 64'd1);
      checkOutput("t2_cycles", bus.cycles, 64'd4);
      checkIdle("t2");

      // Empty run
      resetMonitors(REQ_WRITE, 64'd7);
      applyStimulus(REQ_WRITE, 32'd0, 64'd7);
      waitRunDone("t3_done", 20, waited);
      checkOutput("t3_latency", 64'(waited), 64'd1);
      checkOutput("t3_cycles", bus.cycles, 64'd1);
      checkOutput("t3_grants", 64'(grantCount), 64'd0);
      checkIdle("t3");

      // Engine 2 never raises busy
      dead[2] = 1'b1;
      resetMonitors(REQ_WRITE, 64'd4);
      applyStimulus(REQ_WRITE, 32'd4, 64'd4);
      waitRunDone("t4_done", 400, waited);
      checkOutput("t4_err", 64'(bus.run_err), 64'd1);
      checkOutput("t4_completed", 64'(bus.n_completed), 64'd4);
      checkOutput("t4_cycles", bus.cycles, 64'd258);
      checkOutput("t4_order", orderCode, 64'h2301);
      checkIdle("t4");
      dead[2] = 1'b0;

      // Start during RUN, then an illegal type in IDLE
      resetMonitors(REQ_WRITE, 64'd3);
      applyStimulus(REQ_WRITE, 32'd2, 64'd3);
      checkOutput("t5_err_cleared", 64'(bus.run_err), 64'd0);
      applyStimulus(REQ_READ, 32'd5, 64'd9);
      waitRunDone("t5_done", 50, waited);
      checkOutput("t5_issued", 64'(bus.n_issued), 64'd2);
      checkOutput("t5_cycles", bus.cycles, 64'd7);
      checkOutput("t5_order", orderCode, 64'h23);
      checkIdle("t5");
      applyStimulus(2'b11, 32'd9, 64'd5);
      @(negedge aclk);
      checkOutput("t5_illegal_busy", 64'(bus.run_busy), 64'd0);
      checkOutput("t5_illegal_issued", 64'(bus.n_issued), 64'd2);
      checkOutput("t5_illegal_cycles", bus.cycles, 64'd7);
      checkOutput("t5_illegal_grants", 64'(grantCount), 64'd2);

      // Reset mid-run after three issues
      resetMonitors(REQ_WRITE, 64'd16);
      applyStimulus(REQ_WRITE, 32'd8, 64'd16);
      waited = 0;
      while (bus.n_issued != 32'd3 && waited < 20) begin
         @(negedge aclk);
         waited++;
      end
      checkOutput("t6_issued_before", 64'(bus.n_issued), 64'd3);
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      checkOutput("t6_order_before", orderCode, 64'h0123);
      checkOutput("t6_rst_flags", {61'd0, bus.run_busy, bus.run_done, bus.run_err}, 64'd0);
      checkOutput("t6_rst_cycles", bus.cycles, 64'd0);
      checkOutput("t6_rst_counts", {bus.n_issued, bus.n_completed}, 64'd0);
      checkOutput("t6_rst_eng", 64'(bus.eng_req_type) | 64'(|bus.eng_n_beats), 64'd0);
      checkOutput("t6_no_done", 64'(doneCount), 64'd0);
      resetMonitors(REQ_WRITE, 64'd2);
      applyStimulus(REQ_WRITE, 32'd1, 64'd2);
      waitRunDone("t6_done", 50, waited);
      checkOutput("t6_order_after", orderCode, 64'h1);
      checkOutput("t6_completed", 64'(bus.n_completed), 64'd1);
      checkOutput("t6_cycles", bus.cycles, 64'd5);
      checkIdle("t6");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
